aoi22_pipe: RTL



---
 rtl/aoi22_pipe.sv | 117 +++++++++++
 1 files changed

// File: rtl/aoi22_pipe.sv
// aoi22_pipe
//   Registered, flow-controlled vector AND-OR-INVERT stage:
//   Y = ~((A & B) | (C & D)), evaluated bitwise over WIDTH-bit operands.
//   Operands are captured into a stage-1 register. The AOI22 result is then
//   written into a 2-entry output FIFO. Y and out_valid are driven from the
//   FIFO head.
//
// Ports
//   CLK        rising-edge clock
//   RESET      asynchronous, active-high reset; clears all state
//   in_valid   operand set A/B/C/D is valid
//   in_ready   block can accept an operand set this cycle (registered state only)
//   A,B,C,D    WIDTH-bit operands, sampled on accept
//   out_valid  Y holds a valid result
//   out_ready  consumer takes Y this cycle
//   Y          WIDTH-bit result
//   xfer_cnt   16-bit count of delivered results, wraps modulo 2^16
module aoi22_pipe #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [WIDTH-1:0] C,
    input  logic [WIDTH-1:0] D,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Y,
    output logic [15:0]      xfer_cnt
);

    // Stage-1 operand register
    logic [WIDTH-1:0] s1_a;
    logic [WIDTH-1:0] s1_b;
    logic [WIDTH-1:0] s1_c;
    logic [WIDTH-1:0] s1_d;
    logic             s1_valid;

    // 2-entry output FIFO
    logic [WIDTH-1:0] buf_data [2];
    logic             rd_ptr;
    logic             wr_ptr;
    logic [1:0]       buf_cnt;

    logic             accept;
    logic             pop;
    logic             advance;
    logic [1:0]       occ;
    logic [WIDTH-1:0] aoi_res;

    always_comb begin
        occ       = 2'({1'b0, s1_valid}) + buf_cnt;
        // in_ready depends only on registered occupancy.
        // out_ready has no path to it.
        in_ready  = (occ != 2'd3);
        out_valid = (buf_cnt != 2'd0);
        Y         = buf_data[rd_ptr];
        accept    = in_valid & in_ready;
        pop       = out_valid & out_ready;
        // Stage 1 may move into a full buffer when the head is popped on the same edge.
        advance   = s1_valid & ((buf_cnt != 2'd2) | pop);
        aoi_res   = ~((s1_a & s1_b) | (s1_c & s1_d));
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            s1_a     <= '0;
            s1_b     <= '0;
            s1_c     <= '0;
            s1_d     <= '0;
            s1_valid <= 1'b0;
        end else begin
            if (accept) begin
                s1_a <= A;
                s1_b <= B;
                s1_c <= C;
                s1_d <= D;
            end
            s1_valid <= accept | (s1_valid & ~advance);
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            buf_data[0] <= '0;
            buf_data[1] <= '0;
            rd_ptr      <= 1'b0;
            wr_ptr      <= 1'b0;
            buf_cnt     <= 2'd0;
        end else begin
            if (advance) begin
                buf_data[wr_ptr] <= aoi_res;
                wr_ptr           <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({advance, pop})
                2'b10:   buf_cnt <= buf_cnt + 2'd1;
                2'b01:   buf_cnt <= buf_cnt - 2'd1;
                default: buf_cnt <= buf_cnt;
            endcase
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            xfer_cnt <= '0;
        end else if (pop) begin
            xfer_cnt <= xfer_cnt + 16'd1;
        end
    end

endmodule
